// File: rtl/distance_text_buffer_pkg.sv
// Shared constants for the distance status line: ASCII codes, line length,
// converter state encoding and the double-dabble digit adjust step.
package distance_pkg;

  localparam int TEXT_LEN = 15;

  localparam logic [6:0] CH_SPACE = 7'h20;
  localparam logic [6:0] CH_ZERO  = 7'h30;
  localparam logic [6:0] CH_DASH  = 7'h2D;
  localparam logic [6:0] CH_D     = 7'h44;
  localparam logic [6:0] CH_I     = 7'h49;
  localparam logic [6:0] CH_S     = 7'h53;
  localparam logic [6:0] CH_T     = 7'h54;
  localparam logic [6:0] CH_COLON = 7'h3A;
  localparam logic [6:0] CH_C     = 7'h63;
  localparam logic [6:0] CH_M     = 7'h6D;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_t;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the shift.
  function automatic logic [19:0] bcd_adjust(input logic [19:0] b);
    logic [19:0] r;
    r = b;
    for (int i = 0; i < 5; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/distance_text_buffer_if.sv
// Bundle between the ranging logic / overlay stage and the text buffer.
interface distance_text_buffer_if #(
  parameter int DIST_W = 16
);
  logic [DIST_W-1:0] dist_in;
  logic              dist_valid;
  logic [4:0]        char_xy;
  logic [6:0]        char_code;
  logic              busy;
  logic              done;

  modport master (
    output dist_in, dist_valid, char_xy,
    input  char_code, busy, done
  );

  modport slave (
    input  dist_in, dist_valid, char_xy,
    output char_code, busy, done
  );
endinterface

// File: rtl/distance_text_buffer_bin2bcd_seq.sv
// Sequential double-dabble: one bit per cycle, DIST_W shift cycles, then a
// one-cycle COMMIT state flagged on done while bcd holds the final result.
module bin2bcd_seq
  import distance_pkg::*;
#(
  parameter int DIST_W = 16
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIST_W-1:0] bin,
  output logic              busy,
  output logic              done,
  output logic [19:0]       bcd
);

  conv_state_t state, state_nxt;
  logic [15:0] sr;
  logic [3:0]  cnt;
  logic [19:0] adj;

  always_ff @(posedge pclk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_SHIFT;
      ST_SHIFT:  if (cnt == 4'd0) state_nxt = ST_COMMIT;
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != ST_IDLE);
    done = (state == ST_COMMIT);
  end

  assign adj = bcd_adjust(bcd);

  // Narrow inputs are left-aligned so DIST_W shifts consume every value bit.
  always_ff @(posedge pclk) begin
    if (!rst) begin
      sr  <= '0;
      bcd <= '0;
      cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            sr  <= 16'(bin) << (16 - DIST_W);
            bcd <= '0;
            cnt <= 4'(DIST_W - 1);
          end
        end
        ST_SHIFT: begin
          {bcd, sr} <= {adj[18:0], sr, 1'b0};
          cnt       <= cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/distance_text_buffer.sv
// Status line "DIST: ddddd cm " with a one-deep pending slot in front of the
// converter; display updates atomically and char_code is registered (1 cycle).
module distance_text_buffer
  import distance_pkg::*;
#(
  parameter int DIST_W = 16,
  parameter int MAX_CM = 400
) (
  input logic                   pclk,
  input logic                   rst,
  distance_text_buffer_if.slave bus
);

  localparam logic [DIST_W-1:0] MAX_V = DIST_W'(MAX_CM);

  logic              conv_busy, conv_done, start;
  logic [19:0]       conv_bcd;
  logic [DIST_W-1:0] load_val, pend_val;
  logic              pend_full, over_nxt;
  logic [19:0]       disp_dig;
  logic              disp_over;
  logic              done_r;
  logic [6:0]        code_r, glyph;
  logic [4:1]        blank;

  // A waiting pending value is older than a same-cycle strobe, so it goes first.
  assign start    = !conv_busy && (bus.dist_valid || pend_full);
  assign load_val = pend_full ? pend_val : bus.dist_in;

  bin2bcd_seq #(.DIST_W(DIST_W)) u_conv (
    .pclk  (pclk),
    .rst   (rst),
    .start (start),
    .bin   (load_val),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge pclk) begin
    if (!rst) begin
      pend_full <= 1'b0;
      pend_val  <= '0;
      over_nxt  <= 1'b0;
      disp_dig  <= '0;
      disp_over <= 1'b0;
      done_r    <= 1'b0;
      code_r    <= CH_SPACE;
    end else begin
      if (start) over_nxt <= (load_val > MAX_V);
      if (bus.dist_valid && (conv_busy || pend_full)) begin
        pend_full <= 1'b1;
        pend_val  <= bus.dist_in;
      end else if (start && pend_full) begin
        pend_full <= 1'b0;
      end
      if (conv_done) begin
        disp_dig  <= conv_bcd;
        disp_over <= over_nxt;
      end
      done_r <= conv_done;
      code_r <= glyph;
    end
  end

  function automatic logic [6:0] render(input logic [3:0] n, input logic blk,
                                        input logic over);
    if (over) return CH_DASH;
    if (blk)  return CH_SPACE;
    return CH_ZERO + {3'b000, n};
  endfunction

  always_comb begin
    blank[4] = (disp_dig[19:16] == 4'd0);
    blank[3] = blank[4] && (disp_dig[15:12] == 4'd0);
    blank[2] = blank[3] && (disp_dig[11:8] == 4'd0);
    blank[1] = blank[2] && (disp_dig[7:4] == 4'd0);
  end

  always_comb begin
    glyph = CH_SPACE;
    case (bus.char_xy)
      5'd0:    glyph = CH_D;
      5'd1:    glyph = CH_I;
      5'd2:    glyph = CH_S;
      5'd3:    glyph = CH_T;
      5'd4:    glyph = CH_COLON;
      5'd6:    glyph = render(disp_dig[19:16], blank[4], disp_over);
      5'd7:    glyph = render(disp_dig[15:12], blank[3], disp_over);
      5'd8:    glyph = render(disp_dig[11:8],  blank[2], disp_over);
      5'd9:    glyph = render(disp_dig[7:4],   blank[1], disp_over);
      5'd10:   glyph = render(disp_dig[3:0],   1'b0,     disp_over);
      5'd12:   glyph = CH_C;
      5'd13:   glyph = CH_M;
      default: glyph = CH_SPACE;
    endcase
  end

  assign bus.char_code = code_r;
  assign bus.busy      = conv_busy;
  assign bus.done      = done_r;

endmodule

// File: tb/tb_distance_text_buffer.sv
// Scoreboarded bench: expected digit fields are queued at each strobe and
// popped when done pulses; the line is then read back through char_xy.
module tb_distance_text_buffer;

  logic pclk = 1'b0;
  logic rst  = 1'b0;
  always #5 pclk = ~pclk;

  distance_text_buffer_if #(.DIST_W(16)) bus ();

  distance_text_buffer #(.DIST_W(16), .MAX_CM(400)) dut (
    .pclk (pclk),
    .rst  (rst),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [39:0] sb_q[$];
  logic [39:0] shown;

  function automatic logic [39:0] exp_digits(input int v);
    logic [39:0] r;
    int x;
    if (v > 400) return {5{8'h2D}};
    r = {5{8'h20}};
    x = v;
    for (int i = 0; i < 5; i++) begin
      r[8*i +: 8] = 8'h30 + 8'(x % 10);
      x = x / 10;
      if (x == 0) break;
    end
    return r;
  endfunction

  function automatic logic [6:0] exp_char(input logic [4:0] idx, input logic [39:0] dg);
    logic [119:0] ln;
    logic [7:0]   b;
    if (idx >= 5'd15) return 7'h20;
    ln = {"DIST: ", dg, " cm "};
    b  = ln[119 - 8*idx -: 8];
    return b[6:0];
  endfunction

  task automatic strobe(input int v);
    @(negedge pclk);
    bus.dist_in    = 16'(v);
    bus.dist_valid = 1'b1;
    @(negedge pclk);
    bus.dist_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge pclk);
      #1;
      if (bus.done) begin
        cyc = i;
        ok  = 1'b1;
        break;
      end
    end
  endtask

  task automatic read_line(output logic [119:0] ln);
    ln = '0;
    for (int i = 0; i < 15; i++) begin
      @(negedge pclk);
      bus.char_xy = 5'(i);
      @(negedge pclk);
      ln[119 - 8*i -: 8] = {1'b0, bus.char_code};
    end
  endtask

  task automatic test_reset;
    logic [119:0] ln;
    rst = 1'b0;
    bus.dist_valid = 1'b0;
    bus.dist_in    = '0;
    bus.char_xy    = '0;
    repeat (2) @(negedge pclk);
    n_tests++;
    if (bus.char_code !== 7'h20) begin
      n_fail++;
      $display("FAIL reset_code: got %h expected 20", bus.char_code);
    end
    rst = 1'b1;
    @(negedge pclk);
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got busy=%b done=%b expected 0/0", bus.busy, bus.done);
    end
    read_line(ln);
    n_tests++;
    if (ln !== {"DIST:     0 cm "}) begin
      n_fail++;
      $display("FAIL reset_line: got '%s' expected 'DIST:     0 cm '", ln);
    end
    @(negedge pclk);
    bus.char_xy = 5'd20;
    @(negedge pclk);
    n_tests++;
    if (bus.char_code !== 7'h20) begin
      n_fail++;
      $display("FAIL reset_idx20: got %h expected 20", bus.char_code);
    end
    shown = exp_digits(0);
  endtask

  task automatic test_conversion;
    logic [119:0] ln;
    logic [39:0]  e;
    int cyc;
    bit ok;
    strobe(123);
    sb_q.push_back(exp_digits(123));
    wait_done(cyc, ok);
    n_tests++;
    if (!ok || cyc != 17) begin
      n_fail++;
      $display("FAIL conv_latency: got %0d cycles (seen=%0b) expected 17", cyc, ok);
    end
    e = sb_q.pop_front();
    read_line(ln);
    n_tests++;
    if (ln !== {"DIST: ", e, " cm "}) begin
      n_fail++;
      $display("FAIL conv_123: got '%s' expected 'DIST: %s cm '", ln, e);
    end
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL conv_busy_after: got %b expected 0", bus.busy);
    end
    shown = e;
  endtask

  task automatic test_boundary;
    int vals[3] = '{400, 401, 0};
    logic [119:0] ln;
    logic [39:0]  e;
    int cyc;
    bit ok;
    foreach (vals[i]) begin
      strobe(vals[i]);
      sb_q.push_back(exp_digits(vals[i]));
      wait_done(cyc, ok);
      n_tests++;
      if (!ok) begin
        n_fail++;
        $display("FAIL bound_done_%0d: got no done within 40 cycles expected a pulse", vals[i]);
      end
      e = sb_q.pop_front();
      read_line(ln);
      n_tests++;
      if (ln !== {"DIST: ", e, " cm "}) begin
        n_fail++;
        $display("FAIL bound_%0d: got '%s' expected 'DIST: %s cm '", vals[i], ln, e);
      end
      shown = e;
    end
  endtask

  task automatic test_latency;
    logic [4:0]  prev_xy;
    logic [39:0] cur;
    int dones = 0;
    cur = shown;
    @(negedge pclk);
    bus.char_xy = 5'd0;
    prev_xy = 5'd0;
    for (int k = 0; k < 30; k++) begin
      @(negedge pclk);
      n_tests++;
      if (bus.char_code !== exp_char(prev_xy, cur)) begin
        n_fail++;
        $display("FAIL latency_k%0d_xy%0d: got %h expected %h", k, prev_xy,
                 bus.char_code, exp_char(prev_xy, cur));
      end
      if (bus.done) begin
        dones++;
        if (sb_q.size() > 0) cur = sb_q.pop_front();
      end
      bus.dist_valid = (k == 2);
      if (k == 2) begin
        bus.dist_in = 16'd321;
        sb_q.push_back(exp_digits(321));
      end
      prev_xy = 5'((k + 1) % 15);
      bus.char_xy = prev_xy;
    end
    n_tests++;
    if (dones != 1 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL latency_done: got %0d pulses, %0d left expected 1, 0", dones, sb_q.size());
    end
    shown = cur;
  endtask

  task automatic test_back_to_back;
    logic [4:0]  prev_xy;
    logic [39:0] cur;
    int dones = 0;
    cur = shown;
    @(negedge pclk);
    bus.char_xy = 5'd6;
    prev_xy = 5'd6;
    for (int k = 0; k < 50; k++) begin
      @(negedge pclk);
      n_tests++;
      if (bus.char_code !== exp_char(prev_xy, cur)) begin
        n_fail++;
        $display("FAIL b2b_k%0d_xy%0d: got %h expected %h", k, prev_xy,
                 bus.char_code, exp_char(prev_xy, cur));
      end
      if (bus.done) begin
        dones++;
        if (sb_q.size() > 0) cur = sb_q.pop_front();
      end
      bus.dist_valid = (k == 0 || k == 4 || k == 8);
      if (k == 0) begin
        bus.dist_in = 16'd50;
        sb_q.push_back(exp_digits(50));
      end else if (k == 4) begin
        bus.dist_in = 16'd60;
      end else if (k == 8) begin
        bus.dist_in = 16'd70;
        sb_q.push_back(exp_digits(70));
      end
      prev_xy = 5'(6 + (k + 1) % 5);
      bus.char_xy = prev_xy;
    end
    n_tests++;
    if (dones != 2 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_done: got %0d pulses, %0d left expected 2, 0", dones, sb_q.size());
    end
    n_tests++;
    if (cur !== exp_digits(70)) begin
      n_fail++;
      $display("FAIL b2b_final: got '%s' expected '   70'", cur);
    end
    shown = cur;
  endtask

  task automatic test_reset_mid;
    logic [119:0] ln;
    int activity = 0;
    strobe(999);
    strobe(777);
    repeat (6) @(negedge pclk);
    rst = 1'b0;
    @(negedge pclk);
    rst = 1'b1;
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_busy: got %b expected 0", bus.busy);
    end
    for (int k = 0; k < 30; k++) begin
      @(negedge pclk);
      if (bus.done || bus.busy) activity++;
    end
    n_tests++;
    if (activity != 0) begin
      n_fail++;
      $display("FAIL rstmid_quiet: got %0d busy/done cycles expected 0", activity);
    end
    read_line(ln);
    n_tests++;
    if (ln !== {"DIST:     0 cm "}) begin
      n_fail++;
      $display("FAIL rstmid_line: got '%s' expected 'DIST:     0 cm '", ln);
    end
    shown = exp_digits(0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_conversion();
    test_boundary();
    test_latency();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
